// File: rtl/rx_frame_check.sv
// 4-word frame checker with HUNT/SYNC/LOCKED alignment; outputs registered, one edge after the sampling edge; no backpressure (ready low drops to HUNT).
// Define RX_FRAME_CHECK_STATS_EN to build the frame_cnt/err_cnt statistics counters and honour clr_cnt.
module rx_frame_check #(
    parameter int LOCK_GOOD  = 4,
    parameter int UNLOCK_BAD = 4
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic        ready,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_is_k,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] frame_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    localparam logic [3:0] LG = 4'(LOCK_GOOD);
    localparam logic [3:0] UB = 4'(UNLOCK_BAD);

    state_t      state_q, state_d;
    logic [1:0]  pos_q, pos_d;
    logic        flag_q, flag_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  bad_q, bad_d;
    logic        locked_q, locked_d;
    logic        err_pulse_q, err_pulse_d;
    logic        frame_inc, err_inc;
    logic        mismatch, flag_eff, verdict;

    // {rx_is_k, rx_data} expected at each word position of the frame
    function automatic logic [17:0] exp_word(input logic [1:0] p);
        case (p)
            2'd0:    exp_word = {2'b11, 16'hBCBC};
            2'd1:    exp_word = {2'b00, 16'h5854};
            2'd2:    exp_word = {2'b00, 16'h4034};
            default: exp_word = {2'b00, 16'h23A7};
        endcase
    endfunction

    assign mismatch = ({rx_is_k, rx_data} != exp_word(pos_q));
    assign flag_eff = flag_q | mismatch;
    assign verdict  = (pos_q == 2'd3);

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        flag_d      = flag_q;
        good_d      = good_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        frame_inc   = 1'b0;
        err_inc     = 1'b0;
        if (!ready) begin
            state_d = HUNT;
            pos_d   = 2'd0;
            flag_d  = 1'b0;
            good_d  = 4'd0;
            bad_d   = 4'd0;
        end else begin
            case (state_q)
                HUNT: begin
                    if ({rx_is_k, rx_data} == exp_word(2'd0)) begin
                        state_d = SYNC;
                        pos_d   = 2'd1;
                        good_d  = 4'd0;
                        flag_d  = 1'b0;
                    end else begin
                        pos_d = 2'd0;
                    end
                end
                SYNC: begin
                    pos_d  = pos_q + 2'd1;
                    flag_d = verdict ? 1'b0 : flag_eff;
                    if (verdict) begin
                        if (!flag_eff) begin
                            if (good_q + 4'd1 == LG) begin
                                state_d = LOCKED;
                                good_d  = 4'd0;
                                bad_d   = 4'd0;
                            end else begin
                                good_d = good_q + 4'd1;
                            end
                        end else begin
                            state_d = HUNT;
                            good_d  = 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    pos_d  = pos_q + 2'd1;
                    flag_d = verdict ? 1'b0 : flag_eff;
                    if (verdict) begin
                        if (!flag_eff) begin
                            bad_d     = 4'd0;
                            frame_inc = 1'b1;
                        end else begin
                            err_pulse_d = 1'b1;
                            err_inc     = 1'b1;
                            if (bad_q + 4'd1 == UB) begin
                                state_d = HUNT;
                                bad_d   = 4'd0;
                            end else begin
                                bad_d = bad_q + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    pos_d   = 2'd0;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            pos_q       <= 2'd0;
            flag_q      <= 1'b0;
            good_q      <= 4'd0;
            bad_q       <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            flag_q      <= flag_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

`ifdef RX_FRAME_CHECK_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] err_cnt_q;

    // clear wins over a same-edge increment; err_cnt saturates
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 32'd0;
            err_cnt_q   <= 16'd0;
        end else if (clr_cnt) begin
            frame_cnt_q <= 32'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            if (frame_inc) frame_cnt_q <= frame_cnt_q + 32'd1;
            if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = &{1'b0, clr_cnt, frame_inc, err_inc};
    assign frame_cnt    = 32'd0;
    assign err_cnt      = 16'd0;
`endif

endmodule

// File: doc/rx_frame_check.md
RX_FRAME_CHECK -- requirements
Module: rx_frame_check

Interface
REQ-001 SHALL have parameter LOCK_GOOD, default 4: consecutive good frames required to enter LOCKED (range 1..15).
REQ-002 SHALL have parameter UNLOCK_BAD, default 4: consecutive bad frames in LOCKED that force HUNT (range 1..15).
REQ-003 SHALL have port rx_clk, input, 1: GTP RX user clock; single clock domain, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ready, input, 1: transceiver rx_reset_done; low means input data invalid.
REQ-006 SHALL have port rx_data, input, 16: received word.
REQ-007 SHALL have port rx_is_k, input, 2: per-byte K-character flags, bit0 = rx_data[7:0].
REQ-008 SHALL have port clr_cnt, input, 1: synchronous clear of the statistics counters.
REQ-009 SHALL have port locked, output, 1: high in LOCKED.
REQ-010 SHALL have port err_pulse, output, 1: one-cycle strobe per bad frame while LOCKED.
REQ-011 SHALL have port frame_cnt, output, 32: good frames counted while LOCKED.
REQ-012 SHALL have port err_cnt, output, 16: bad frames counted while LOCKED.

Function
REQ-013 SHALL define a frame as 4 words: W0 = 0xBCBC with rx_is_k = 2'b11, then W1 = 0x5854, W2 = 0x4034, W3 = 0x23A7, each with rx_is_k = 2'b00.
REQ-014 SHALL implement states HUNT, SYNC and LOCKED, plus a 2-bit word position pos.
REQ-015 In HUNT, a sampled W0 SHALL move to SYNC with pos = 1, good count = 0 and the frame-error flag cleared; any other word SHALL keep HUNT.
REQ-016 In SYNC and LOCKED, pos SHALL advance by 1 every cycle and wrap 3 -> 0; a word whose data or rx_is_k differs from the expected word for its pos SHALL set the frame-error flag.
REQ-017 The frame verdict SHALL be taken at the edge that samples pos = 3: good if the flag is clear, bad if set; the flag SHALL then clear for the next frame.
REQ-018 In SYNC, a good frame SHALL increment the good count; reaching LOCK_GOOD SHALL enter LOCKED on that same edge; a bad frame SHALL return to HUNT.
REQ-019 In LOCKED, a good frame SHALL clear the bad count and increment frame_cnt (wraps modulo 2^32).
REQ-020 In LOCKED, a bad frame SHALL assert err_pulse for exactly the next cycle, increment err_cnt (saturates at 0xFFFF) and increment the bad count; reaching UNLOCK_BAD SHALL enter HUNT on that edge, with locked low from that edge.
REQ-021 A mid-frame comma in SYNC or LOCKED SHALL be treated as a mismatch only; it SHALL NOT realign pos.
REQ-022 ready low SHALL force HUNT on the next edge, clear pos and the good/bad counts, and hold frame_cnt and err_cnt.
REQ-023 clr_cnt SHALL zero frame_cnt and err_cnt on the next edge; clr_cnt SHALL take priority over a simultaneous increment.
REQ-024 All outputs SHALL be registered; latency from the sampling edge to the output change is one edge.

Reset
REQ-025 reset SHALL asynchronously force: HUNT, pos = 0, good/bad counts = 0, locked = 0, err_pulse = 0, frame_cnt = 0, err_cnt = 0.
REQ-026 Release of reset SHALL take effect on the first rx_clk edge after deassertion; reset asserted mid-frame SHALL discard the partial frame.

Configuration
REQ-027 Macro RX_FRAME_CHECK_STATS_EN defined: frame_cnt, err_cnt and clr_cnt SHALL function as specified.
REQ-028 Macro RX_FRAME_CHECK_STATS_EN undefined: frame_cnt and err_cnt SHALL be constant 0, clr_cnt SHALL be ignored, and no counter registers SHALL be synthesized; locked and err_pulse SHALL be unaffected.

Verification
REQ-029 reset release, ready = 1, continuous correct frames starting at W0 -> locked rises on the edge sampling W3 of frame 4; frame_cnt = 1 after frame 5.
REQ-030 Locked, W2 corrupted to 0x4035 in one frame -> err_pulse high for 1 cycle, err_cnt = 1, locked stays 1, the next good frame clears the bad count.
REQ-031 Locked, 4 consecutive frames with W1 = 0x0000 -> locked falls on the edge sampling W3 of the 4th bad frame, err_cnt = 4, relock after 4 good frames.
REQ-032 Locked, ready pulled low for 1 cycle -> HUNT next edge, locked = 0, frame_cnt and err_cnt unchanged.
REQ-033 clr_cnt asserted on the same edge as a good-frame verdict -> frame_cnt = 0; err_cnt forced to 0xFFFF then one more bad frame -> stays 0xFFFF.
REQ-034 RX_FRAME_CHECK_STATS_EN undefined, rerun REQ-029 and REQ-030 -> identical locked and err_pulse behaviour, counters read 0.
